// File: rtl/btb_port_scheduler_if.sv
// btb_port_scheduler_if: IF-lookup, EX-update and table-port signals of the BTB port scheduler.
interface btb_port_scheduler_if #(
    parameter int ENTRY_BIT  = 5,
    parameter int DATA_WIDTH = 59
);
    logic                  lookup_req;
    logic [ENTRY_BIT-1:0]  lookup_idx;
    logic                  upd_valid;
    logic [ENTRY_BIT-1:0]  upd_idx;
    logic [DATA_WIDTH-1:0] upd_data;
    logic                  upd_ready;
    logic                  lookup_grant;
    logic                  mem_en;
    logic                  mem_we;
    logic [ENTRY_BIT-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  byp_valid;
    logic [DATA_WIDTH-1:0] byp_data;
    logic                  init_busy;
    logic [2:0]            q_count;

    modport master (
        output lookup_req, lookup_idx, upd_valid, upd_idx, upd_data,
        input  upd_ready, lookup_grant, mem_en, mem_we, mem_addr, mem_wdata,
               byp_valid, byp_data, init_busy, q_count
    );

    modport slave (
        input  lookup_req, lookup_idx, upd_valid, upd_idx, upd_data,
        output upd_ready, lookup_grant, mem_en, mem_we, mem_addr, mem_wdata,
               byp_valid, byp_data, init_busy, q_count
    );
endinterface

// File: rtl/btb_port_scheduler.sv
// btb_port_scheduler: shares one single-port BTB table between IF lookups and queued EX updates,
// clearing the table after reset and forwarding queued updates to lookups.
module btb_port_scheduler #(
    parameter int ENTRY_BIT  = 5,
    parameter int DATA_WIDTH = 59,
    parameter int DEPTH      = 4
) (
    input logic clk,
    input logic reset,
    btb_port_scheduler_if.slave bus
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int PW = $clog2(DEPTH);

    logic [0:0]            state_q, state_d;
    logic [ENTRY_BIT-1:0]  init_ptr_q, init_ptr_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ENTRY_BIT-1:0]  qidx_q [DEPTH];
    logic [DATA_WIDTH-1:0] qdata_q [DEPTH];
    logic                  run, full, push, pop, byp_v;
    logic [DATA_WIDTH-1:0] byp_d;

    always_comb begin
        run        = state_q == RUN;
        full       = cnt_q == 3'(DEPTH);
        push       = run && bus.upd_valid && !full;
        // a full queue wins the port so the EX stage can make progress
        pop        = run && cnt_q != 3'd0 && (!bus.lookup_req || full);
        state_d    = (!run && &init_ptr_q) ? RUN : state_q;
        init_ptr_d = run ? init_ptr_q : init_ptr_q + ENTRY_BIT'(1);
        head_d     = head_q + PW'(pop);
        tail_d     = tail_q + PW'(push);
        cnt_d      = cnt_q + 3'(push) - 3'(pop);
    end

    // scan oldest to youngest so the youngest match overrides; popping head still counts
    always_comb begin
        byp_v = 1'b0;
        byp_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (3'(k) < cnt_q && qidx_q[head_q + PW'(k)] == bus.lookup_idx) begin
                byp_v = 1'b1;
                byp_d = qdata_q[head_q + PW'(k)];
            end
        end
    end

    assign bus.upd_ready    = run && !full;
    assign bus.lookup_grant = run && !pop && bus.lookup_req;
    assign bus.mem_en       = !run || pop || bus.lookup_req;
    assign bus.mem_we       = !run || pop;
    assign bus.mem_addr     = !run ? init_ptr_q : pop ? qidx_q[head_q] : bus.lookup_idx;
    assign bus.mem_wdata    = pop ? qdata_q[head_q] : '0;
    assign bus.byp_valid    = bus.lookup_grant && byp_v;
    assign bus.byp_data     = bus.lookup_grant ? byp_d : '0;
    assign bus.init_busy    = !run;
    assign bus.q_count      = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qidx_q[tail_q]  <= bus.upd_idx;
            qdata_q[tail_q] <= bus.upd_data;
        end
    end
endmodule

// File: tb/tb_btb_port_scheduler.sv
// tb_btb_port_scheduler: directed plus random stimulus; a queue-based reference model predicts
// every cycle's outputs, and a separate monitor compares them on the falling edge.
module tb_btb_port_scheduler;
    localparam int EB = 5;
    localparam int DW = 59;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    btb_port_scheduler_if #(.ENTRY_BIT(EB), .DATA_WIDTH(DW)) bus();
    btb_port_scheduler #(.ENTRY_BIT(EB), .DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [EB-1:0] idx;
        logic [DW-1:0] data;
    } upd_t;

    typedef struct packed {
        logic en, we, rdy, gnt, bv, busy;
        logic [2:0] cnt;
        logic [EB-1:0] addr;
        logic [DW-1:0] wdata, bd;
        logic ck_addr, ck_wdata;
    } obs_t;

    upd_t mq[$];
    obs_t exp_q[$];
    int init_left = 0;
    bit mvalid = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic c_rst, c_req, c_uv;
    logic [EB-1:0] c_li, c_ui;
    logic [DW-1:0] c_ud;

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    function automatic obs_t predict();
        obs_t e = '0;
        e.cnt = 3'(mq.size());
        if (init_left > 0) begin
            e.en = 1'b1; e.we = 1'b1; e.busy = 1'b1;
            e.addr = EB'((1 << EB) - init_left);
            e.ck_addr = 1'b1; e.ck_wdata = 1'b1;
        end else begin
            e.rdy = mq.size() < 4;
            if (mq.size() > 0 && (!c_req || mq.size() == 4)) begin
                e.en = 1'b1; e.we = 1'b1;
                e.addr = mq[0].idx; e.wdata = mq[0].data;
                e.ck_addr = 1'b1; e.ck_wdata = 1'b1;
            end else if (c_req) begin
                e.en = 1'b1; e.gnt = 1'b1;
                e.addr = c_li; e.ck_addr = 1'b1;
                foreach (mq[i]) if (mq[i].idx == c_li) begin
                    e.bv = 1'b1;
                    e.bd = mq[i].data;
                end
            end
        end
        return e;
    endfunction

    task automatic step();
        bit ready, drain;
        if (c_rst) begin
            mvalid = 1'b1;
            init_left = 1 << EB;
            mq.delete();
        end else if (mvalid) begin
            if (init_left > 0) init_left--;
            else begin
                ready = mq.size() < 4;
                drain = mq.size() > 0 && (!c_req || mq.size() == 4);
                if (drain) void'(mq.pop_front());
                if (c_uv && ready) mq.push_back('{idx: c_ui, data: c_ud});
            end
        end
    endtask

    task automatic drive();
        reset = c_rst;
        bus.lookup_req = c_req;
        bus.lookup_idx = c_li;
        bus.upd_valid = c_uv;
        bus.upd_idx = c_ui;
        bus.upd_data = c_ud;
    endtask

    task automatic tick(input logic r, input logic rq, input logic [EB-1:0] li,
                        input logic uv, input logic [EB-1:0] ui, input logic [DW-1:0] ud);
        @(posedge clk);
        step();
        #1;
        c_rst = r; c_req = rq; c_li = li; c_uv = uv; c_ui = ui; c_ud = ud;
        drive();
        if (mvalid) exp_q.push_back(predict());
    endtask

    initial begin
        obs_t e, a;
        bit ok;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '0;
                a.en = bus.mem_en; a.we = bus.mem_we; a.rdy = bus.upd_ready;
                a.gnt = bus.lookup_grant; a.bv = bus.byp_valid; a.busy = bus.init_busy;
                a.cnt = bus.q_count; a.addr = bus.mem_addr; a.wdata = bus.mem_wdata;
                a.bd = bus.byp_data;
                ok = a.en === e.en && a.we === e.we && a.rdy === e.rdy && a.gnt === e.gnt &&
                     a.bv === e.bv && a.busy === e.busy && a.cnt === e.cnt &&
                     (!e.ck_addr || a.addr === e.addr) && (!e.ck_wdata || a.wdata === e.wdata) &&
                     (!e.bv || a.bd === e.bd);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got en=%b we=%b addr=%h wdata=%h rdy=%b gnt=%b bv=%b bd=%h busy=%b cnt=%0d; expected en=%b we=%b addr=%h wdata=%h rdy=%b gnt=%b bv=%b bd=%h busy=%b cnt=%0d",
                             cyc, a.en, a.we, a.addr, a.wdata, a.rdy, a.gnt, a.bv, a.bd, a.busy, a.cnt,
                             e.en, e.we, e.addr, e.wdata, e.rdy, e.gnt, e.bv, e.bd, e.busy, e.cnt);
                end
            end
        end
    end

    initial begin
        c_rst = 1'b1; c_req = 1'b0; c_li = '0; c_uv = 1'b0; c_ui = '0; c_ud = '0;
        drive();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        // full clear, then idle with the queue empty
        repeat (40) tick(0, 0, 0, 0, 0, 0);
        // lookups held while the queue fills: the full queue then takes the port
        tick(0, 1, 9, 1, 3, rnd());
        tick(0, 1, 9, 1, 5, rnd());
        tick(0, 1, 9, 1, 3, rnd());
        tick(0, 1, 9, 1, 7, rnd());
        tick(0, 1, 3, 1, 9, rnd());
        repeat (5) tick(0, 1, EB'($urandom_range(0, 9)), 0, 0, 0);
        repeat (6) tick(0, 0, 0, 0, 0, 0);
        // two writes to one index: youngest must be forwarded, then drained in order
        tick(0, 1, 0, 1, 3, 59'h0AAAA_AAAA_AAAA);
        tick(0, 1, 0, 1, 3, 59'h0BBBB_BBBB_BBBB);
        tick(0, 1, 3, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        // push while draining keeps the count steady
        tick(0, 1, 0, 1, 1, rnd());
        tick(0, 1, 0, 1, 2, rnd());
        tick(0, 0, 0, 1, 4, rnd());
        repeat (4) tick(0, 0, 0, 0, 0, 0);
        // reset with pending updates discards them and restarts the clear
        tick(0, 1, 0, 1, 10, rnd());
        tick(0, 1, 0, 1, 11, rnd());
        tick(0, 1, 0, 1, 12, rnd());
        tick(1, 0, 0, 0, 0, 0);
        repeat (40) tick(0, 0, 0, 0, 0, 0);
        repeat (3000)
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, EB'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), EB'($urandom_range(0, 7)), rnd());
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/btb_port_scheduler.md
BTB_PORT_SCHEDULER -- requirements
Module: btb_port_scheduler

Interface
REQ-001 SHALL have parameter ENTRY_BIT, default 5, table index width; table holds 2^ENTRY_BIT entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 59, packed entry width {val, is_branch, tag[24:0], target[31:0]}.
REQ-003 SHALL have parameter DEPTH, fixed 4, update-queue depth.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 lookup_req  input  1  IF stage requests a table read this cycle.
REQ-007 lookup_idx  input  ENTRY_BIT  IF read index.
REQ-008 upd_valid  input  1  EX stage offers a table write.
REQ-009 upd_idx  input  ENTRY_BIT  write index.
REQ-010 upd_data  input  DATA_WIDTH  write data.
REQ-011 upd_ready  output  1  queue accepts the offered update.
REQ-012 lookup_grant  output  1  table port serves the lookup this cycle.
REQ-013 mem_en, mem_we  output  1 each  single-port table enable and write enable.
REQ-014 mem_addr  output  ENTRY_BIT  table address.
REQ-015 mem_wdata  output  DATA_WIDTH  table write data.
REQ-016 byp_valid  output  1  a queued update matches lookup_idx.
REQ-017 byp_data  output  DATA_WIDTH  data of the youngest matching queued update.
REQ-018 init_busy  output  1  table clear in progress.
REQ-019 q_count  output  3  queued updates, 0..4.

Function
REQ-020 FSM SHALL have two states, INIT and RUN.
REQ-021 INIT: each cycle mem_en=1, mem_we=1, mem_addr=init_ptr, mem_wdata=0; init_ptr increments by 1.
REQ-022 INIT: upd_ready=0, lookup_grant=0, init_busy=1, byp_valid=0.
REQ-023 INIT SHALL transition to RUN on the cycle after the write to address 2^ENTRY_BIT-1; INIT lasts exactly 2^ENTRY_BIT cycles.
REQ-024 RUN: upd_ready = (q_count < 4); update enqueues at tail on a clock edge with upd_valid && upd_ready.
REQ-025 RUN: drain condition = q_count>0 && (!lookup_req || q_count==4).
REQ-026 RUN, drain: mem_en=1, mem_we=1, mem_addr/mem_wdata = head entry, lookup_grant=0; head pops at the clock edge.
REQ-027 RUN, no drain, lookup_req=1: mem_en=1, mem_we=0, mem_addr=lookup_idx, lookup_grant=1.
REQ-028 RUN, idle (no drain, no lookup_req): mem_en=0, mem_we=0, lookup_grant=0.
REQ-029 Lookup has priority over draining unless the queue is full; a full queue forces a drain and denies the lookup (IF stalls).
REQ-030 Push and pop in the same cycle SHALL leave q_count unchanged; FIFO order preserved; pointers wrap modulo 4.
REQ-031 Bypass is combinational over queued entries only (not the same-cycle upd input); youngest match wins; byp_valid=0 when none match or lookup_grant=0.
REQ-032 An entry popped this cycle still participates in bypass this cycle.
REQ-033 Queued writes to the same index SHALL reach the table in enqueue order; the last one wins.

Reset
REQ-034 On reset: state=INIT, init_ptr=0, q_count=0, queue contents discarded; outputs take INIT values (REQ-021/022) from the first post-reset cycle onward.
REQ-035 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear from address 0; pending updates are lost.

Verification
REQ-036 Reset, idle for 40 cycles -> mem_we=1 for exactly 32 cycles, addresses 0..31, data 0; init_busy falls at cycle 32; upd_ready=1 from then on.
REQ-037 RUN, lookup_req held 1, push 4 updates to idx 3,5,3,7 -> q_count reaches 4, upd_ready=0; next cycle lookup_grant=0 and drain writes idx 3.
REQ-038 RUN, queue holds idx 3 (data A) then idx 3 (data B), lookup_idx=3 -> byp_valid=1, byp_data=B.
REQ-039 RUN, q_count=2, lookup_req=0 -> two consecutive writes in enqueue order, then mem_en=0, q_count=0.
REQ-040 RUN, q_count=2, simultaneous push and drain -> q_count stays 2; later drain order matches push order.
REQ-041 Reset asserted with q_count=3 -> q_count=0 next cycle, INIT restarts at address 0, no queued data is ever written.
